flush_sequencer: RTL and testbench
==================================

FLUSH_SEQUENCER -- requirements
Module: flush_sequencer

Interface
- REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning the number of consecutive cycles IF/ID is cleared per flush (legal 1..15).
- REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
- REQ-003 SHALL have port system_reset, input, 1, asynchronous active-high reset.
- REQ-004 SHALL have port flush_req, input, 1, annul/flush request from reset_handler (branch with a=1, or system reset path).
- REQ-005 SHALL have port stall, input, 1, hazard-unit stall; IF/ID is held while high.
- REQ-006 SHALL have port if_id_clr, output, 1, synchronous clear of the IF/ID register (instruction becomes NOP).
- REQ-007 SHALL have port id_nop_sel, output, 1, selects all-zero control word into ID/EX.
- REQ-008 SHALL have port flush_busy, output, 1, high while a flush is pending or in progress.
- REQ-009 SHALL have port annul_count, output, 16, count of completed flush events (present only with FLUSH_STATS_EN).

Function
- REQ-010 SHALL implement states IDLE, PENDING, FLUSH.
- REQ-011 In IDLE, when flush_req=1 and stall=0, if_id_clr and id_nop_sel SHALL be 1 in the same cycle (combinational, zero latency); if FLUSH_CYCLES>1, next state SHALL be FLUSH with remaining counter = FLUSH_CYCLES-1; otherwise it SHALL remain in IDLE.
- REQ-012 In IDLE, when flush_req=1 and stall=1, if_id_clr SHALL stay 0, and next state SHALL be PENDING with the full FLUSH_CYCLES count latched.
- REQ-013 In PENDING, flush_busy SHALL be 1 and if_id_clr 0 while stall=1; in the first cycle with stall=0, if_id_clr and id_nop_sel SHALL be 1, with transition to FLUSH (count-1 remaining) or to IDLE if FLUSH_CYCLES=1.
- REQ-014 In FLUSH, if_id_clr and id_nop_sel SHALL be 1 while stall=0, and the remaining counter SHALL decrement each non-stalled cycle; on reaching 0 the state SHALL become IDLE.
- REQ-015 In FLUSH, stall=1 SHALL freeze the counter and force if_id_clr=0 (id_nop_sel stays 1).
- REQ-016 A flush_req arriving in PENDING or FLUSH SHALL re-arm the counter to FLUSH_CYCLES without counting as a separate event (merge).
- REQ-017 flush_busy SHALL be 1 in PENDING and FLUSH, and combinationally 1 in IDLE when flush_req=1.
- REQ-018 The counter SHALL be 4 bits and never underflow; FLUSH_CYCLES=0 or >15 SHALL be a compile-time error.

Reset
- REQ-019 system_reset=1 SHALL asynchronously force state IDLE, counter 0, and annul_count 0.
- REQ-020 During reset, if_id_clr and id_nop_sel SHALL be 1 and flush_busy 0, so the pipeline fills with NOPs.
- REQ-021 Reset asserted mid-flush SHALL discard any pending or merged request.

Configuration
- REQ-022 With FLUSH_STATS_EN defined, annul_count SHALL increment by 1 per flush event entering PENDING or FLUSH, or completing in IDLE, and saturate at 16'hFFFF.
- REQ-023 Without FLUSH_STATS_EN, the port and its logic SHALL be absent.

Structure
- REQ-024 A shared package flush_pkg SHALL hold the state enum (IDLE=2'b00, PENDING=2'b01, FLUSH=2'b10), CNT_W=4, and STATS_W=16.
- REQ-025 The saturating event counter SHALL be a sub-module sat_counter, instantiated only under FLUSH_STATS_EN.

Verification
- REQ-026 FLUSH_CYCLES=1: pulse flush_req 1 cycle with stall=0. Required: if_id_clr=1 in that cycle only; state stays IDLE; annul_count=1.
- REQ-027 FLUSH_CYCLES=3: pulse flush_req with stall=0. Required: if_id_clr high exactly 3 cycles; flush_busy low after the third.
- REQ-028 flush_req with stall=1 held for 2 cycles. Required: if_id_clr=0 for 2 cycles, then 1 in the cycle stall drops.
- REQ-029 FLUSH_CYCLES=3: second flush_req in the 2nd flush cycle. Required: 4 total clear cycles; annul_count increments by 1 only.
- REQ-030 Assert system_reset in the FLUSH state. Required: state IDLE, flush_busy=0, and if_id_clr=1 during reset. Preload annul_count to 16'hFFFF, then apply a flush. Required: it stays 16'hFFFF.

Source files
------------

// File: rtl/flush_pkg.sv
// Shared types and widths for the IF/ID flush sequencer and its event counter.
package flush_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    FLUSH   = 2'b10
  } flush_state_t;

  localparam int CNT_W   = 4;
  localparam int STATS_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used to tally flush events; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/flush_sequencer.sv
// Clears IF/ID for FLUSH_CYCLES unstalled cycles per flush request, deferring under stall.
// Optional FLUSH_STATS_EN adds the annul_count event counter port.
module flush_sequencer
  import flush_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                system_reset,
  input  logic                flush_req,
  input  logic                stall,
  output logic                if_id_clr,
  output logic                id_nop_sel,
  output logic                flush_busy,
  output flush_state_t        state
`ifdef FLUSH_STATS_EN
  ,
  output logic [STATS_W-1:0]  annul_count
`endif
);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_cycles
    $error("flush_sequencer: FLUSH_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] FULL_LESS = CNT_W'(FLUSH_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load;
  logic             clr_c;
  logic             nop_c;
  logic             busy_c;

  // A request while busy re-arms the remaining count; the current cycle still counts.
  always_comb begin
    load   = flush_req ? FULL : cnt;
    clr_c  = 1'b0;
    nop_c  = 1'b0;
    busy_c = 1'b0;
    case (state)
      IDLE: begin
        clr_c  = flush_req & ~stall;
        nop_c  = flush_req & ~stall;
        busy_c = flush_req;
      end
      PENDING: begin
        clr_c  = ~stall;
        nop_c  = ~stall;
        busy_c = 1'b1;
      end
      FLUSH: begin
        clr_c  = ~stall;
        nop_c  = 1'b1;
        busy_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset drives NOPs into the pipeline while reporting not busy.
  assign if_id_clr  = system_reset | clr_c;
  assign id_nop_sel = system_reset | nop_c;
  assign flush_busy = ~system_reset & busy_c;

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            if (stall) begin
              state <= PENDING;
              cnt   <= FULL;
            end else if (FULL > CNT_W'(1)) begin
              state <= FLUSH;
              cnt   <= FULL_LESS;
            end
          end
        end
        PENDING, FLUSH: begin
          if (stall) begin
            cnt <= load;
          end else if (load <= CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            state <= FLUSH;
            cnt   <= load - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef FLUSH_STATS_EN
  sat_counter #(.W(STATS_W)) u_stats (
    .clk   (clk),
    .rst   (system_reset),
    .inc   ((state == IDLE) && flush_req),
    .count (annul_count)
  );
`endif

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: one instance with FLUSH_CYCLES=1, one with 3.
module tb_flush_sequencer;
  import flush_pkg::*;

  logic clk;
  logic rst;
  logic r1, s1, clr1, nop1, busy1;
  logic r3, s3, clr3, nop3, busy3;
  flush_state_t st1, st3;
`ifdef FLUSH_STATS_EN
  logic [STATS_W-1:0] cnt1, cnt3;
`endif

  int vectors;
  int miscompares;

  flush_sequencer #(.FLUSH_CYCLES(1)) d1 (
    .clk(clk), .system_reset(rst), .flush_req(r1), .stall(s1),
    .if_id_clr(clr1), .id_nop_sel(nop1), .flush_busy(busy1), .state(st1)
`ifdef FLUSH_STATS_EN
    , .annul_count(cnt1)
`endif
  );

  flush_sequencer #(.FLUSH_CYCLES(3)) d3 (
    .clk(clk), .system_reset(rst), .flush_req(r3), .stall(s3),
    .if_id_clr(clr3), .id_nop_sel(nop3), .flush_busy(busy3), .state(st3)
`ifdef FLUSH_STATS_EN
    , .annul_count(cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++; if (clr1 !== 1'b1) begin miscompares++; $display("FAIL reset_clr1 got=%b exp=1", clr1); end
    vectors++; if (nop1 !== 1'b1) begin miscompares++; $display("FAIL reset_nop1 got=%b exp=1", nop1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    vectors++; if (st3 !== IDLE) begin miscompares++; $display("FAIL reset_state3 got=%0d exp=0", st3); end
    vectors++; if (clr3 !== 1'b1) begin miscompares++; $display("FAIL reset_clr3 got=%b exp=1", clr3); end
    @(negedge clk); rst = 1'b0; #1;
    vectors++; if (clr1 !== 1'b0 || busy1 !== 1'b0) begin miscompares++; $display("FAIL post_reset1 clr=%b busy=%b exp=0/0", clr1, busy1); end
    vectors++; if (clr3 !== 1'b0 || busy3 !== 1'b0) begin miscompares++; $display("FAIL post_reset3 clr=%b busy=%b exp=0/0", clr3, busy3); end
`ifdef FLUSH_STATS_EN
    vectors++; if (cnt1 !== 16'd0) begin miscompares++; $display("FAIL reset_count1 got=%0d exp=0", cnt1); end
`endif
  endtask

  task automatic test_single();
    @(negedge clk); r1 = 1'b1; s1 = 1'b0; #1;
    vectors++; if ({clr1, nop1, busy1} !== 3'b111) begin miscompares++; $display("FAIL single_fire got=%b exp=111", {clr1, nop1, busy1}); end
    @(negedge clk); r1 = 1'b0; #1;
    vectors++; if ({clr1, nop1, busy1} !== 3'b000) begin miscompares++; $display("FAIL single_after got=%b exp=000", {clr1, nop1, busy1}); end
    vectors++; if (st1 !== IDLE) begin miscompares++; $display("FAIL single_state got=%0d exp=0", st1); end
`ifdef FLUSH_STATS_EN
    vectors++; if (cnt1 !== 16'd1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", cnt1); end
`endif
  endtask

  task automatic test_multi();
    logic [4:0] exp_clr;
    int clears;
    exp_clr = 5'b00111;
    clears = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); r3 = (i == 0); s3 = 1'b0; #1;
      if (clr3 === 1'b1) clears++;
      vectors++; if (clr3 !== exp_clr[i] || busy3 !== exp_clr[i]) begin miscompares++; $display("FAIL multi_cyc%0d clr=%b busy=%b exp=%b", i, clr3, busy3, exp_clr[i]); end
    end
    vectors++; if (clears != 3) begin miscompares++; $display("FAIL multi_clears got=%0d exp=3", clears); end
    vectors++; if (st3 !== IDLE) begin miscompares++; $display("FAIL multi_state got=%0d exp=0", st3); end
  endtask

  task automatic test_stall_pending();
    @(negedge clk); r1 = 1'b1; s1 = 1'b1; #1;
    vectors++; if ({clr1, busy1} !== 2'b01) begin miscompares++; $display("FAIL pend_c0 clr/busy=%b exp=01", {clr1, busy1}); end
    @(negedge clk); r1 = 1'b0; #1;
    vectors++; if ({clr1, busy1} !== 2'b01 || st1 !== PENDING) begin miscompares++; $display("FAIL pend_c1 clr/busy=%b state=%0d exp=01/1", {clr1, busy1}, st1); end
    @(negedge clk); s1 = 1'b0; #1;
    vectors++; if ({clr1, nop1, busy1} !== 3'b111) begin miscompares++; $display("FAIL pend_release got=%b exp=111", {clr1, nop1, busy1}); end
    @(negedge clk); #1;
    vectors++; if ({clr1, busy1} !== 2'b00 || st1 !== IDLE) begin miscompares++; $display("FAIL pend_done clr/busy=%b state=%0d exp=00/0", {clr1, busy1}, st1); end
`ifdef FLUSH_STATS_EN
    vectors++; if (cnt1 !== 16'd2) begin miscompares++; $display("FAIL pend_count got=%0d exp=2", cnt1); end
`endif
  endtask

  task automatic test_stall_in_flush();
    logic [4:0] exp_stall, exp_clr, exp_nop;
    exp_stall = 5'b00010;
    exp_clr   = 5'b01101;
    exp_nop   = 5'b01111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); r3 = (i == 0); s3 = exp_stall[i]; #1;
      vectors++;
      if (clr3 !== exp_clr[i] || nop3 !== exp_nop[i] || busy3 !== exp_nop[i]) begin
        miscompares++;
        $display("FAIL fstall_cyc%0d clr=%b nop=%b busy=%b exp=%b/%b/%b", i, clr3, nop3, busy3, exp_clr[i], exp_nop[i], exp_nop[i]);
      end
    end
    s3 = 1'b0;
  endtask

  task automatic test_merge();
    logic [5:0] exp_clr;
    int clears;
    exp_clr = 6'b001111;
    clears = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); r3 = (i == 0) || (i == 1); s3 = 1'b0; #1;
      if (clr3 === 1'b1) clears++;
      vectors++; if (clr3 !== exp_clr[i]) begin miscompares++; $display("FAIL merge_cyc%0d clr=%b exp=%b", i, clr3, exp_clr[i]); end
    end
    vectors++; if (clears != 4) begin miscompares++; $display("FAIL merge_clears got=%0d exp=4", clears); end
`ifdef FLUSH_STATS_EN
    vectors++; if (cnt3 !== 16'd3) begin miscompares++; $display("FAIL merge_count got=%0d exp=3", cnt3); end
`endif
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk); r3 = 1'b1; s3 = 1'b0;
    @(negedge clk); #1;
    vectors++; if (st3 !== FLUSH) begin miscompares++; $display("FAIL rmid_pre state=%0d exp=2", st3); end
    #1 rst = 1'b1; #1;
    vectors++; if (st3 !== IDLE) begin miscompares++; $display("FAIL rmid_state got=%0d exp=0", st3); end
    vectors++; if ({clr3, nop3, busy3} !== 3'b110) begin miscompares++; $display("FAIL rmid_outs got=%b exp=110", {clr3, nop3, busy3}); end
    @(negedge clk); rst = 1'b0; r3 = 1'b0; #1;
    vectors++; if ({clr3, busy3} !== 2'b00) begin miscompares++; $display("FAIL rmid_release clr/busy=%b exp=00", {clr3, busy3}); end
    @(negedge clk); #1;
    vectors++; if ({clr3, busy3} !== 2'b00 || st3 !== IDLE) begin miscompares++; $display("FAIL rmid_discard clr/busy=%b state=%0d exp=00/0", {clr3, busy3}, st3); end
`ifdef FLUSH_STATS_EN
    vectors++; if (cnt3 !== 16'd0) begin miscompares++; $display("FAIL rmid_count got=%0d exp=0", cnt3); end
`endif
  endtask

`ifdef FLUSH_STATS_EN
  task automatic test_saturate();
    @(negedge clk); r1 = 1'b1; s1 = 1'b0;
    repeat (65536) @(negedge clk);
    #1;
    vectors++; if (cnt1 !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got=%h exp=ffff", cnt1); end
    @(negedge clk); r1 = 1'b0;
    @(negedge clk); r1 = 1'b1; #1;
    vectors++; if (clr1 !== 1'b1) begin miscompares++; $display("FAIL sat_flush_clr got=%b exp=1", clr1); end
    @(negedge clk); r1 = 1'b0; #1;
    vectors++; if (cnt1 !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%h exp=ffff", cnt1); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    r1 = 1'b0; s1 = 1'b0;
    r3 = 1'b0; s3 = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_stall_pending();
    test_stall_in_flush();
    test_merge();
    test_reset_mid_flush();
`ifdef FLUSH_STATS_EN
    test_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
